fifo_rr_write_arbiter: RTL and testbench

//  Shares one synchronous FIFO among N_REQ write requesters using round-robin arbitration with burst lock.

---
 rtl/fifo_arb_pkg.sv | 32 +++
 rtl/sync_fifo_core.sv | 55 +++++
 rtl/fifo_rr_write_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_rr_write_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants, types and the round-robin pick helper for the shared-FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned N_REQ      = 4;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ID_WIDTH   = 2;
  localparam int unsigned ENTRY_W    = DATA_WIDTH + ID_WIDTH;

  // {found, idx} with found=0 means no requester is asking.
  localparam logic [ID_WIDTH:0] RR_NONE = '0;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Scan last+1, last+2, ... modulo N_REQ and return the first active requester.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [N_REQ-1:0]    req,
                                                input logic [ID_WIDTH-1:0] last);
    logic [ID_WIDTH:0]   res;
    logic [ID_WIDTH-1:0] idx;
    res = RR_NONE;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = ID_WIDTH'((32'(last) + k) % N_REQ);
      if (!res[ID_WIDTH] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered read data and wrap-bit pointers.
module sync_fifo_core #(
  parameter int unsigned WIDTH      = fifo_arb_pkg::ENTRY_W,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] w_ptr_q, r_ptr_q;
  logic [WIDTH-1:0]    rd_data_q;
  logic                do_wr, do_rd;

  assign empty = (w_ptr_q == r_ptr_q);
  assign full  = (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]) &&
                 (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]);
  assign count = w_ptr_q - r_ptr_q;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = rd_data_q;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[w_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_wr) begin
        w_ptr_q <= w_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_data_q <= mem[r_ptr_q[ADDR_WIDTH-1:0]];
        r_ptr_q   <= r_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin, burst-locked arbitration of N_REQ writers into one shared FIFO.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [ID_WIDTH-1:0]         rd_src,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic [ADDR_WIDTH:0]         count
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [BurstW-1:0]   burst_inc;
  logic                rd_valid_q;

  logic [ID_WIDTH:0]   pick;
  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                lock_hit;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                wr_en;
  logic [ENTRY_W-1:0]  wr_data;
  logic [ENTRY_W-1:0]  fifo_rd_data;

  assign pick       = rr_pick(req, last_q);
  assign pick_found = pick[ID_WIDTH];
  assign pick_idx   = pick[ID_WIDTH-1:0];
  assign lock_hit   = (state_q == LOCK) && req[owner_q];
  assign gnt_idx    = lock_hit ? owner_q : pick_idx;
  assign burst_inc  = burst_q + 1'b1;

  // A granted requester is by construction asserting req, so a grant is an accept.
  assign wr_en   = !rst && !full && (lock_hit || pick_found);
  assign gnt     = wr_en ? (N_REQ'(1) << gnt_idx) : '0;
  assign wr_data = {gnt_idx, wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH]};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    if (wr_en) begin
      if (lock_hit) begin
        burst_d = burst_inc;
        if (burst_inc == BurstW'(MAX_BURST)) begin
          state_d = IDLE;
        end
      end else begin
        owner_d = pick_idx;
        last_d  = pick_idx;
        burst_d = BurstW'(1);
        state_d = (MAX_BURST > 1) ? LOCK : IDLE;
      end
    end else if (!full && (state_q == LOCK) && !req[owner_q]) begin
      // Owner went quiet and nobody else asked: drop the lock anyway.
      state_d = IDLE;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= ID_WIDTH'(N_REQ - 1);
      burst_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      rd_valid_q <= rd_en && !empty;
    end
  end

  sync_fifo_core #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign {rd_src, rd_data} = fifo_rd_data;
  assign rd_valid          = rd_valid_q;

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literals.
module tb_fifo_rr_write_arbiter;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int MB    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        rd_en;
  logic [3:0]  gnt;
  logic [7:0]  rd_data;
  logic [1:0]  rd_src;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  always #5 clk = ~clk;

  fifo_rr_write_arbiter #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_src   (rd_src),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [9:0] mq[$];
  bit         m_locked;
  int         m_owner, m_last, m_burst;
  logic [7:0] m_rd_data;
  logic [1:0] m_rd_src;
  bit         m_rd_valid;

  // DUT outputs sampled mid-cycle by the last step.
  logic [3:0] s_gnt, s_count;
  logic [7:0] s_rd_data;
  logic [1:0] s_rd_src;
  logic       s_rd_valid, s_full, s_empty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_locked   = 0;
    m_owner    = 0;
    m_last     = 3;
    m_burst    = 0;
    m_rd_data  = '0;
    m_rd_src   = '0;
    m_rd_valid = 0;
  endtask

  function automatic int m_pick(input logic r, input logic [3:0] rq);
    if (r || mq.size() == DEPTH) return -1;
    if (m_locked && rq[m_owner]) return m_owner;
    for (int k = 1; k <= 4; k++) begin
      if (rq[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  // One clock: drive, compare against the model, then advance the model across the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                      input logic re);
    int         g;
    logic [3:0] eg;
    logic [9:0] e;
    bit         was_full;
    @(negedge clk);
    rst = r; req = rq; wdata = wd; rd_en = re;
    #1;
    g  = m_pick(r, rq);
    eg = (g < 0) ? 4'b0 : 4'(1 << g);
    s_gnt = gnt; s_count = count; s_full = full; s_empty = empty;
    s_rd_data = rd_data; s_rd_src = rd_src; s_rd_valid = rd_valid;
    chk("gnt", gnt, eg);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("rd_valid", rd_valid, m_rd_valid);
    chk("rd_data", rd_data, m_rd_data);
    chk("rd_src", rd_src, m_rd_src);
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      was_full   = (mq.size() == DEPTH);
      m_rd_valid = 0;
      if (re && mq.size() != 0) begin
        e          = mq.pop_front();
        m_rd_src   = e[9:8];
        m_rd_data  = e[7:0];
        m_rd_valid = 1;
      end
      if (g >= 0) begin
        mq.push_back({2'(g), wd[g*8 +: 8]});
        if (m_locked && g == m_owner) begin
          m_burst++;
          if (m_burst == MB) m_locked = 0;
        end else begin
          m_owner  = g;
          m_last   = g;
          m_burst  = 1;
          m_locked = (MB > 1);
        end
      end else if (m_locked && !rq[m_owner] && !was_full) begin
        m_locked = 0;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] t2_src[8];
    logic [1:0] t3_src[3];
    t2_src = '{0, 0, 0, 0, 1, 1, 1, 1};
    t3_src = '{0, 0, 2};
    rst = 1'b1; req = '0; wdata = '0; rd_en = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);

    // Reset with all requesting, then first grant.
    step(1, 4'hF, 32'h44332211, 0);
    chk("t1_gnt_rst", s_gnt, 4'b0000);
    chk("t1_empty", s_empty, 1);
    chk("t1_count", s_count, 0);
    step(0, 4'hF, $urandom, 0);
    chk("t1_gnt_first", s_gnt, 4'b0001);

    // Burst of 4 to req0, then req1, then full.
    for (int k = 2; k <= 9; k++) begin
      step(0, 4'hF, $urandom, 0);
      if (k == 4) chk("t2_gnt_burst_end", s_gnt, 4'b0001);
      if (k == 5) chk("t2_gnt_move", s_gnt, 4'b0010);
      if (k == 9) begin
        chk("t2_gnt_full", s_gnt, 4'b0000);
        chk("t2_full", s_full, 1);
        chk("t2_count", s_count, 8);
      end
    end
    for (int k = 0; k <= 8; k++) begin
      step(0, 4'h0, 32'h0, k < 8);
      if (k > 0) begin
        chk("t2_rd_valid", s_rd_valid, 1);
        chk("t2_rd_src", s_rd_src, t2_src[k-1]);
      end
    end

    // Burst break: req0 drops after two writes, req2 takes over at once.
    step(1, 4'h0, 32'h0, 0);
    step(0, 4'b0101, $urandom, 0);
    step(0, 4'b0101, $urandom, 0);
    step(0, 4'b0100, $urandom, 0);
    chk("t3_gnt_break", s_gnt, 4'b0100);
    for (int k = 0; k <= 3; k++) begin
      step(0, 4'h0, 32'h0, k < 3);
      if (k > 0) chk("t3_rd_src", s_rd_src, t3_src[k-1]);
    end

    // Full with simultaneous read and req1 pending.
    step(1, 4'h0, 32'h0, 0);
    repeat (8) step(0, 4'hF, $urandom, 0);
    step(0, 4'b0010, $urandom, 1);
    chk("t4_gnt_full", s_gnt, 4'b0000);
    chk("t4_full", s_full, 1);
    step(0, 4'b0010, $urandom, 0);
    chk("t4_gnt_after", s_gnt, 4'b0010);
    chk("t4_count_dip", s_count, 7);
    step(0, 4'h0, 32'h0, 0);
    chk("t4_count_back", s_count, 8);

    // Write into empty FIFO with a read that must be ignored.
    step(1, 4'h0, 32'h0, 0);
    step(0, 4'b0001, 32'h000000A5, 1);
    chk("t5_gnt", s_gnt, 4'b0001);
    step(0, 4'h0, 32'h0, 1);
    chk("t5_no_valid", s_rd_valid, 0);
    chk("t5_not_empty", s_empty, 0);
    step(0, 4'h0, 32'h0, 0);
    chk("t5_valid", s_rd_valid, 1);
    chk("t5_data", s_rd_data, 8'hA5);
    chk("t5_src", s_rd_src, 0);

    // Wrap-around: 20 interleaved writes/reads, then a fill and drain across the MSB flip.
    step(1, 4'h0, 32'h0, 0);
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) step(0, 4'(1 << $urandom_range(3)), $urandom, 0);
      else            step(0, 4'h0, 32'h0, 1);
    end
    repeat (9) step(0, 4'hF, $urandom, 0);
    chk("t6_full", s_full, 1);
    repeat (9) step(0, 4'h0, 32'h0, 1);
    chk("t6_empty", s_empty, 1);

    // Randomized traffic with occasional resets and varying read pressure.
    for (int k = 0; k < 3000; k++) begin
      int rbias;
      rbias = (k / 300) % 3;
      step(($urandom_range(199) == 0), 4'($urandom), $urandom,
           (rbias == 0) ? ($urandom_range(3) == 0) :
           (rbias == 1) ? ($urandom_range(1) == 0) : ($urandom_range(3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
